// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one synchronous-read data RAM between a CPU port (0) and a loader
//   port (1). One access is issued per cycle. Ties are broken round robin.
//   The loader can hold ownership for a burst of up to MAX_LOCK grants with
//   lock1.
//
// Ports
//   clk_25mhz, reset           : clock (rising edge), async active-high reset
//   req/we/addr/wdata 0,1      : access request from each port
//   ack0, ack1                 : access driven onto the RAM pins this cycle
//   rvalid0/1, rdata0/1        : read data return, one cycle after ack
//   lock1                      : loader asks to keep ownership for a burst
//   ram_we/addr/wdata/rdata    : RAM side (read data valid the cycle after addr)
//   dbg_state                  : 1 while the FSM is in LOCK1
//
// Handshake: a port raises reqN with weN/addrN/wdataN and holds all four
// stable until it sees ackN high. The request is consumed in the ackN cycle.
// The requester may drop or change the request in the following cycle.
// Nothing is buffered here.
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dbg_state
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {RR = 1'b0, LOCK1 = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;  // 1: port 1 was granted last
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic              grant0, grant1;

  logic              rd_pend;    // a read was issued last cycle
  logic              rd_owner;   // which port issued it
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Grant and next-state logic. Grants are forced low while reset is held,
  // so the RAM stays idle even if requests are already up.
  always_comb begin
    grant0         = 1'b0;
    grant1         = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    lock_cnt_nxt   = lock_cnt;
    if (!reset) begin
      case (state)
        RR: begin
          if (req0 && (!req1 || last_grant)) grant0 = 1'b1;
          else if (req1)                     grant1 = 1'b1;
          if (grant1 && lock1 && (MAX_LOCK > 1)) begin
            state_nxt    = LOCK1;
            lock_cnt_nxt = CNT_W'(1);
          end
        end
        LOCK1: begin
          grant1 = req1;
          if (!lock1) begin
            state_nxt    = RR;
            lock_cnt_nxt = '0;
          end else if (req1) begin
            // This grant is the MAX_LOCK-th of the burst. Hand back to RR.
            // last_grant becomes 1 below, so a waiting port 0 wins next.
            if (lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
              state_nxt    = RR;
              lock_cnt_nxt = '0;
            end else begin
              lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
          end
        end
        default: state_nxt = RR;
      endcase
      if (grant0)      last_grant_nxt = 1'b0;
      else if (grant1) last_grant_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state      <= RR;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rd_pend    <= (grant0 && !we0) || (grant1 && !we1);
      rd_owner   <= grant1;
      if (rvalid0) rdata0_q <= ram_rdata;
      if (rvalid1) rdata1_q <= ram_rdata;
    end
  end

  assign ack0      = grant0;
  assign ack1      = grant1;
  assign ram_we    = (grant0 && we0) || (grant1 && we1);
  assign ram_addr  = grant1 ? addr1  : addr0;
  assign ram_wdata = grant1 ? wdata1 : wdata0;

  // RAM data arrives in the cycle after the address. Return it directly in
  // that cycle. Otherwise show the last value each port captured.
  assign rvalid0   = rd_pend && !rd_owner;
  assign rvalid1   = rd_pend &&  rd_owner;
  assign rdata0    = rvalid0 ? ram_rdata : rdata0_q;
  assign rdata1    = rvalid1 ? ram_rdata : rdata1_q;

  assign dbg_state = (state == LOCK1);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1, lock1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_LOCK(16)) dut (
    .clk_25mhz(clk), .reset(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  // Unwritten words read as 0xC0DE0000 | addr.
  logic [31:0] mem [0:255];
  bit          written [0:255];
  always @(posedge clk) begin
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : (32'hC0DE0000 | {24'h0, ram_addr});
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
  end

  // Move to 1 time unit after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    req0 = 1; we0 = 1; req1 = 1; we1 = 1; lock1 = 1;
    @(negedge clk);
    total_cnt++; if ({ack0, ack1, rvalid0, rvalid1, ram_we} !== 5'b0)
      $display("FAIL reset_ctrl got=%b exp=00000", {ack0, ack1, rvalid0, rvalid1, ram_we}); else pass_cnt++;
    total_cnt++; if ({rdata0, rdata1} !== 64'h0)
      $display("FAIL reset_rdata got=%h exp=0", {rdata0, rdata1}); else pass_cnt++;
    total_cnt++; if (dbg_state !== 1'b0)
      $display("FAIL reset_state got=%b exp=0", dbg_state); else pass_cnt++;
    tick();
    rst = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_basic_read();
    req0 = 1; we0 = 0; addr0 = 8'h10;
    req1 = 1; we1 = 0; addr1 = 8'h20;
    @(negedge clk);
    total_cnt++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b1000)
      $display("FAIL basic_c0 got=%b exp=1000", {ack0, ack1, rvalid0, rvalid1}); else pass_cnt++;
    total_cnt++; if (ram_addr !== 8'h10)
      $display("FAIL basic_addr0 got=%h exp=10", ram_addr); else pass_cnt++;
    tick();
    req0 = 0;
    @(negedge clk);
    total_cnt++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0110)
      $display("FAIL basic_c1 got=%b exp=0110", {ack0, ack1, rvalid0, rvalid1}); else pass_cnt++;
    total_cnt++; if (rdata0 !== 32'hC0DE0010)
      $display("FAIL basic_rdata0 got=%h exp=c0de0010", rdata0); else pass_cnt++;
    total_cnt++; if (ram_addr !== 8'h20)
      $display("FAIL basic_addr1 got=%h exp=20", ram_addr); else pass_cnt++;
    tick();
    req1 = 0;
    @(negedge clk);
    total_cnt++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0001)
      $display("FAIL basic_c2 got=%b exp=0001", {ack0, ack1, rvalid0, rvalid1}); else pass_cnt++;
    total_cnt++; if (rdata1 !== 32'hC0DE0020)
      $display("FAIL basic_rdata1 got=%h exp=c0de0020", rdata1); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0000)
      $display("FAIL basic_c3 got=%b exp=0000", {ack0, ack1, rvalid0, rvalid1}); else pass_cnt++;
    total_cnt++; if ({rdata0, rdata1} !== {32'hC0DE0010, 32'hC0DE0020})
      $display("FAIL basic_hold got=%h exp=c0de0010c0de0020", {rdata0, rdata1}); else pass_cnt++;
    tick();
  endtask

  task automatic test_alternate();
    int n0 = 0;
    int n1 = 0;
    req0 = 1; we0 = 0; addr0 = 8'h30;
    req1 = 1; we1 = 0; addr1 = 8'h31;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n0 += int'(ack0);
      n1 += int'(ack1);
      total_cnt++; if ({ack0, ack1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alt_ack[%0d] got=%b exp=%b", i, {ack0, ack1}, (i % 2 == 0) ? 2'b10 : 2'b01); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if ({rvalid0, rvalid1} !== ((i % 2 == 1) ? 2'b10 : 2'b01))
          $display("FAIL alt_rvalid[%0d] got=%b exp=%b", i, {rvalid0, rvalid1}, (i % 2 == 1) ? 2'b10 : 2'b01); else pass_cnt++;
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    total_cnt++; if (n0 !== 4 || n1 !== 4)
      $display("FAIL alt_counts got=%0d,%0d exp=4,4", n0, n1); else pass_cnt++;
    total_cnt++; if ({rvalid0, rvalid1, rdata0, rdata1} !== {2'b01, 32'hC0DE0030, 32'hC0DE0031})
      $display("FAIL alt_tail got=%b %h %h exp=01 c0de0030 c0de0031", {rvalid0, rvalid1}, rdata0, rdata1); else pass_cnt++;
    tick();
  endtask

  task automatic test_lock_burst();
    req1 = 1; we1 = 1; addr1 = 8'h05; wdata1 = 32'hDEADBEEF; lock1 = 1;
    req0 = 0; we0 = 0; addr0 = 8'h05;
    for (int i = 0; i < 20; i++) begin
      if (i == 1)  req0 = 1;
      if (i == 17) req0 = 0;
      @(negedge clk);
      total_cnt++; if ({ack0, ack1, ram_we} !== ((i == 16) ? 3'b100 : 3'b011))
        $display("FAIL lock_ack[%0d] got=%b exp=%b", i, {ack0, ack1, ram_we}, (i == 16) ? 3'b100 : 3'b011); else pass_cnt++;
      total_cnt++; if ({rvalid0, rvalid1} !== ((i == 17) ? 2'b10 : 2'b00))
        $display("FAIL lock_rvalid[%0d] got=%b exp=%b", i, {rvalid0, rvalid1}, (i == 17) ? 2'b10 : 2'b00); else pass_cnt++;
      if (i == 15 || i == 16) begin
        total_cnt++; if (dbg_state !== (i == 15))
          $display("FAIL lock_state[%0d] got=%b exp=%b", i, dbg_state, (i == 15)); else pass_cnt++;
      end
      if (i == 17) begin
        total_cnt++; if (rdata0 !== 32'hDEADBEEF)
          $display("FAIL lock_rdata0 got=%h exp=deadbeef", rdata0); else pass_cnt++;
      end
      tick();
    end
  endtask

  // Continues from the LOCK1 state left by test_lock_burst.
  task automatic test_lock_idle();
    req1 = 0; lock1 = 1; req0 = 1; we0 = 0; addr0 = 8'h05;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total_cnt++; if ({ack0, ack1, ram_we, dbg_state} !== 4'b0001)
        $display("FAIL idle[%0d] got=%b exp=0001", j, {ack0, ack1, ram_we, dbg_state}); else pass_cnt++;
      tick();
    end
    req1 = 1; lock1 = 0;
    @(negedge clk);
    total_cnt++; if ({ack0, ack1} !== 2'b01)
      $display("FAIL idle_release got=%b exp=01", {ack0, ack1}); else pass_cnt++;
    tick();
    req1 = 0;
    @(negedge clk);
    total_cnt++; if ({ack0, ack1, dbg_state} !== 3'b100)
      $display("FAIL idle_p0 got=%b exp=100", {ack0, ack1, dbg_state}); else pass_cnt++;
    tick();
    req0 = 0;
    @(negedge clk);
    total_cnt++; if ({rvalid0, rdata0} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL idle_rd got=%b %h exp=1 deadbeef", rvalid0, rdata0); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    req0 = 1; we0 = 0; addr0 = 8'h40;
    @(negedge clk);
    total_cnt++; if ({ack0, ram_addr} !== {1'b1, 8'h40})
      $display("FAIL mid_ack got=%b %h exp=1 40", ack0, ram_addr); else pass_cnt++;
    tick();
    req0 = 0; rst = 1;
    @(negedge clk);
    total_cnt++; if ({ack0, ack1, rvalid0, rvalid1, ram_we, dbg_state} !== 6'b0)
      $display("FAIL mid_rst got=%b exp=000000", {ack0, ack1, rvalid0, rvalid1, ram_we, dbg_state}); else pass_cnt++;
    total_cnt++; if ({rdata0, rdata1} !== 64'h0)
      $display("FAIL mid_rdata got=%h exp=0", {rdata0, rdata1}); else pass_cnt++;
    tick();
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total_cnt++; if ({rvalid0, rvalid1, rdata0} !== {2'b00, 32'h0})
        $display("FAIL mid_after[%0d] got=%b %h exp=00 0", k, {rvalid0, rvalid1}, rdata0); else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_read();
    test_alternate();
    test_lock_burst();
    test_lock_idle();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
